pipeline_hazard_ctrl: RTL

// - Sequences the 5-stage RV32 pipeline around the instruction decoder: tracks in-flight

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 46 ++++
 rtl/pipeline_hazard_ctrl_if.sv | 36 +++
 rtl/pipeline_hazard_ctrl_hazard_scoreboard.sv | 68 ++++++
 rtl/pipeline_hazard_ctrl.sv | 123 ++++++++++++
 4 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl_pkg
// Shared types for the RV32 pipeline hazard controller:
//   - state_e    : controller states (RUN / STALL / FLUSH)
//   - inst_id_e  : decoded instruction IDs produced by the instruction decoder
//   - uses_rs1 / uses_rs2 / writes_rd : register-usage classification
// ---------------------------------------------------------------------------
package pipeline_hazard_ctrl_pkg;

  localparam int INST_ID_W = 4;  // width of the decoder instruction ID
  localparam int REG_W     = 5;  // architectural register index width
  localparam int CNT_W     = 2;  // flush counter width (FLUSH_CYC is 1..3)

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  typedef enum logic [INST_ID_W-1:0] {
    ID_NOP  = 4'd0,
    ID_ADDI = 4'd1,
    ID_ANDI = 4'd2,
    ID_ADD  = 4'd3,
    ID_AND  = 4'd4,
    ID_SUB  = 4'd5,
    ID_BNE  = 4'd6,
    ID_LW   = 4'd7,
    ID_SW   = 4'd8,
    ID_JAL  = 4'd9
  } inst_id_e;

  function automatic logic uses_rs1(inst_id_e id);
    return id inside {ID_ADDI, ID_ANDI, ID_ADD, ID_AND, ID_SUB, ID_BNE, ID_LW, ID_SW};
  endfunction

  function automatic logic uses_rs2(inst_id_e id);
    return id inside {ID_ADD, ID_AND, ID_SUB, ID_BNE, ID_SW};
  endfunction

  // Branches and stores are the only instructions without a destination.
  function automatic logic writes_rd(inst_id_e id);
    return !(id inside {ID_BNE, ID_SW});
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl_if
// Bundle between the decoder / IF / EX logic and the hazard controller.
//   ID side   : id_vld, id_rs1, id_rs2, id_rd, id_instID, id_jmp_vld
//   EX side   : ex_br_taken
//   Controls  : stall_if, stall_id, bubble_ex, flush_if, flush_id, busy
// master = pipeline side (drives ID/EX status), slave = hazard controller.
// ---------------------------------------------------------------------------
interface pipeline_hazard_ctrl_if;
  import pipeline_hazard_ctrl_pkg::*;

  logic                 id_vld;
  logic [REG_W-1:0]     id_rs1;
  logic [REG_W-1:0]     id_rs2;
  logic [REG_W-1:0]     id_rd;
  logic [INST_ID_W-1:0] id_instID;
  logic                 id_jmp_vld;
  logic                 ex_br_taken;
  logic                 stall_if;
  logic                 stall_id;
  logic                 bubble_ex;
  logic                 flush_if;
  logic                 flush_id;
  logic                 busy;

  modport master (
    output id_vld, id_rs1, id_rs2, id_rd, id_instID, id_jmp_vld, ex_br_taken,
    input  stall_if, stall_id, bubble_ex, flush_if, flush_id, busy
  );

  modport slave (
    input  id_vld, id_rs1, id_rs2, id_rd, id_instID, id_jmp_vld, ex_br_taken,
    output stall_if, stall_id, bubble_ex, flush_if, flush_id, busy
  );

endinterface

// File: rtl/pipeline_hazard_ctrl_hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard
// Tracks destination registers of instructions in EX, MEM and WB as a shift
// register (index 0 = EX) and flags a RAW match against the ID sources.
// Ports:
//   clk, rst            clock, asynchronous active-high reset (clears valids)
//   push_v_i            entry entering EX is a real register write
//   push_rd_i           its destination register
//   push_load_i         it is a load (result only available after MEM)
//   rs1_i/rs2_i         ID source registers
//   use1_i/use2_i       ID instruction is valid and reads that source
//   match_o             RAW hazard that forwarding cannot cover
// ---------------------------------------------------------------------------
module hazard_scoreboard
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int FWD_EN   = 1,
  parameter int SB_DEPTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_v_i,
  input  logic [REG_W-1:0] push_rd_i,
  input  logic             push_load_i,
  input  logic [REG_W-1:0] rs1_i,
  input  logic [REG_W-1:0] rs2_i,
  input  logic             use1_i,
  input  logic             use2_i,
  output logic             match_o
);

  // With forwarding only the EX slot can hurt (load-use); without it, EX and
  // MEM both hazard. WB writes in the first half-cycle, so it never matches.
  localparam int WIN = (FWD_EN != 0) ? 1 : 2;

  logic [SB_DEPTH-1:0] v_q;
  logic [SB_DEPTH-1:0] ld_q;
  logic [REG_W-1:0]    rd_q [SB_DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q <= '0;
    end else begin
      v_q <= {v_q[SB_DEPTH-2:0], push_v_i};
    end
  end

  // Payload only matters where the matching valid bit is set.
  always_ff @(posedge clk) begin
    rd_q[0] <= push_rd_i;
    ld_q[0] <= push_load_i;
    for (int i = 1; i < SB_DEPTH; i++) begin
      rd_q[i] <= rd_q[i-1];
      ld_q[i] <= ld_q[i-1];
    end
  end

  always_comb begin
    match_o = 1'b0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      if ((i < WIN) && v_q[i] && ((FWD_EN == 0) || ld_q[i])) begin
        if (use1_i && (rs1_i != '0) && (rs1_i == rd_q[i])) match_o = 1'b1;
        if (use2_i && (rs2_i != '0) && (rs2_i == rd_q[i])) match_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl
// Stall/flush/bubble sequencer for the 5-stage RV32 pipeline.
// Ports:
//   clk   pipeline clock
//   rst   asynchronous active-high reset
//   bus   slave side of pipeline_hazard_ctrl_if:
//           in : id_vld, id_rs1, id_rs2, id_rd, id_instID, id_jmp_vld, ex_br_taken
//           out: stall_if, stall_id, bubble_ex, flush_if, flush_id, busy
// All outputs are combinational from state, scoreboard and ID inputs, and are
// forced low while rst is high and during the first cycle after release.
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int FWD_EN    = 1,
  parameter int FLUSH_CYC = 1,
  parameter int SB_DEPTH  = 3
) (
  input logic                   clk,
  input logic                   rst,
  pipeline_hazard_ctrl_if.slave bus
);

  inst_id_e         inst;
  logic             use1, use2, hazard;
  logic             init_q;
  logic             active;
  logic             issue;
  logic             push_v;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stall_if, stall_id, bubble_ex, flush_if, flush_id, busy;

  assign inst = inst_id_e'(bus.id_instID);
  assign use1 = bus.id_vld & uses_rs1(inst);
  assign use2 = bus.id_vld & uses_rs2(inst);

  // Only real register writes occupy the scoreboard; x0 is never a write.
  assign push_v = issue & writes_rd(inst) & (bus.id_rd != '0);

  hazard_scoreboard #(
    .FWD_EN   (FWD_EN),
    .SB_DEPTH (SB_DEPTH)
  ) u_sb (
    .clk         (clk),
    .rst         (rst),
    .push_v_i    (push_v),
    .push_rd_i   (bus.id_rd),
    .push_load_i (inst == ID_LW),
    .rs1_i       (bus.id_rs1),
    .rs2_i       (bus.id_rs2),
    .use1_i      (use1),
    .use2_i      (use2),
    .match_o     (hazard)
  );

  always_comb begin
    active    = ~rst & ~init_q;
    stall_if  = 1'b0;
    stall_id  = 1'b0;
    bubble_ex = 1'b0;
    flush_if  = 1'b0;
    flush_id  = 1'b0;
    issue     = 1'b0;
    state_d   = state_q;
    cnt_d     = cnt_q;
    if (active) begin
      unique case (state_q)
        ST_FLUSH: begin
          flush_id  = 1'b1;
          bubble_ex = 1'b1;
          if (cnt_q == '0) state_d = ST_RUN;
          else             cnt_d   = cnt_q - CNT_W'(1);
        end
        default: begin
          // RUN and STALL share the priority chain: branch > hazard > JAL.
          if (bus.ex_br_taken) begin
            flush_if  = 1'b1;
            flush_id  = 1'b1;
            bubble_ex = 1'b1;
            state_d   = ST_FLUSH;
            cnt_d     = CNT_W'(FLUSH_CYC);
          end else if (hazard) begin
            stall_if  = 1'b1;
            stall_id  = 1'b1;
            bubble_ex = 1'b1;
            state_d   = ST_STALL;
          end else begin
            // A JAL only redirects fetch once it actually issues.
            flush_if  = bus.id_jmp_vld & bus.id_vld;
            issue     = bus.id_vld;
            state_d   = ST_RUN;
          end
        end
      endcase
    end else if (!rst) begin
      // First cycle after reset: controls held low, so ID flows into EX.
      issue = bus.id_vld;
    end
    busy = active & (state_q != ST_RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
      init_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      init_q  <= 1'b0;
    end
  end

  assign bus.stall_if  = stall_if;
  assign bus.stall_id  = stall_id;
  assign bus.bubble_ex = bubble_ex;
  assign bus.flush_if  = flush_if;
  assign bus.flush_id  = flush_id;
  assign bus.busy      = busy;

endmodule
